// File: rtl/adf4030_trig_sequencer.sv
// ADF4030 BSYNC-aligned multi-channel trigger sequencer.
// A trigger rising edge arms the sequencer; the next bsync_event starts a run. In each BSYNC
// period every enabled channel emits a pulse of ch_width clocks starting at ch_phase. The run
// lasts repeat_count+1 periods.
// Optional build macro: ADF4030_TRIG_CONTINUOUS_EN. When it is defined, repeat_count all-ones
// runs until abort or loss of bsync_ready.
module adf4030_trig_sequencer #(
   parameter int unsigned CHANNEL_COUNT = 4,
   parameter int unsigned PHASE_WIDTH   = 16,
   parameter int unsigned PULSE_WIDTH   = 8,
   parameter int unsigned REPEAT_WIDTH  = 8
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               trigger,
   input  logic                               abort,
   input  logic                               bsync_event,
   input  logic                               bsync_ready,
   input  logic [PHASE_WIDTH-1:0]             bsync_ratio,
   input  logic [CHANNEL_COUNT-1:0]           ch_en,
   input  logic [CHANNEL_COUNT*PHASE_WIDTH-1:0] ch_phase,
   input  logic [CHANNEL_COUNT*PULSE_WIDTH-1:0] ch_width,
   input  logic [REPEAT_WIDTH-1:0]            repeat_count,
   output logic [CHANNEL_COUNT-1:0]           trig_out,
   output logic                               busy,
   output logic [1:0]                         state,
   output logic                               done,
   output logic                               align_error,
   output logic [CHANNEL_COUNT-1:0]           phase_error
);

   // Common width for window arithmetic so phase and pulse fields compare without truncation
   localparam int unsigned CmpW =
      ((PHASE_WIDTH > PULSE_WIDTH) ? PHASE_WIDTH : PULSE_WIDTH) + 1;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArmed = 2'd1,
      StRun   = 2'd2,
      StDone  = 2'd3
   } state_e;

   state_e                             state_q, state_d;
   logic                               trigger_q;
   logic [PHASE_WIDTH-1:0]             cnt_q, cnt_d;
   logic [REPEAT_WIDTH-1:0]            pidx_q, pidx_d;
   logic [CHANNEL_COUNT-1:0]           en_q;
   logic [CHANNEL_COUNT*PHASE_WIDTH-1:0] phase_q;
   logic [CHANNEL_COUNT*PULSE_WIDTH-1:0] width_q;
   logic [REPEAT_WIDTH-1:0]            repeat_q;
   logic [PHASE_WIDTH-1:0]             ratio_q;
   logic [CHANNEL_COUNT-1:0]           trig_q, trig_d;
   logic                               done_q, done_d;
   logic                               align_q, align_d;
   logic [CHANNEL_COUNT-1:0]           perr_q, perr_d;

   logic                               trig_edge;
   logic                               last_cnt;
   logic                               period_end;
   logic                               last_period;
   logic                               continuous;
   logic                               latch_cfg;
   logic                               clr_perr;
   logic [CHANNEL_COUNT-1:0]           fire;
   logic [CHANNEL_COUNT-1:0]           bad_phase;

   assign trig_edge  = trigger & ~trigger_q;
   assign last_cnt   = (cnt_q == (ratio_q - PHASE_WIDTH'(1)));
   // A misaligned bsync_event still closes the current period
   assign period_end = last_cnt | bsync_event;

`ifdef ADF4030_TRIG_CONTINUOUS_EN
   assign continuous = &repeat_q;
`else
   assign continuous = 1'b0;
`endif

   assign last_period = (pidx_q == repeat_q) & ~continuous;

   // Per-channel window decode on the current period count, using the latched configuration
   always_comb begin
      fire = '0;
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
         logic [PHASE_WIDTH-1:0] ph;
         logic [PULSE_WIDTH-1:0] wd;
         logic [CmpW-1:0]        offs;
         ph   = phase_q[i*PHASE_WIDTH +: PHASE_WIDTH];
         wd   = width_q[i*PULSE_WIDTH +: PULSE_WIDTH];
         offs = CmpW'(cnt_q) - CmpW'(ph);
         fire[i] = en_q[i] & ~perr_q[i] & (wd != '0) & (cnt_q >= ph) & (offs < CmpW'(wd));
      end
   end

   // Phase check on the live configuration, captured at the start of a run
   always_comb begin
      bad_phase = '0;
      for (int i = 0; i < CHANNEL_COUNT; i++) begin
         bad_phase[i] = ch_en[i] & (ch_phase[i*PHASE_WIDTH +: PHASE_WIDTH] >= bsync_ratio);
      end
   end

   // Sequencer next-state, period counting and registered-output next values
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pidx_d    = pidx_q;
      latch_cfg = 1'b0;
      clr_perr  = 1'b0;
      trig_d    = '0;
      done_d    = 1'b0;
      align_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!abort && trig_edge && bsync_ready && (bsync_ratio != '0)) begin
               state_d  = StArmed;
               clr_perr = 1'b1;
            end
         end
         StArmed: begin
            if (abort || !bsync_ready) begin
               state_d = StIdle;
            end else if (bsync_event) begin
               state_d   = StRun;
               latch_cfg = 1'b1;
               cnt_d     = '0;
               pidx_d    = '0;
            end
         end
         StRun: begin
            if (abort || !bsync_ready) begin
               state_d = StIdle;
               cnt_d   = '0;
               pidx_d  = '0;
            end else begin
               trig_d  = fire;
               align_d = bsync_event & ~last_cnt;
               if (period_end) begin
                  cnt_d = '0;
                  if (last_period) begin
                     state_d = StDone;
                     done_d  = 1'b1;
                  end else if (pidx_q != '1) begin
                     // Saturates only in continuous mode; otherwise last_period hits first
                     pidx_d = pidx_q + REPEAT_WIDTH'(1);
                  end
               end else begin
                  cnt_d = cnt_q + PHASE_WIDTH'(1);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
      endcase
   end

   // Sticky phase errors: cleared when arming, accumulated when a run starts
   always_comb begin
      perr_d = perr_q;
      if (clr_perr) begin
         perr_d = '0;
      end else if (latch_cfg) begin
         perr_d = perr_q | bad_phase;
      end
   end

   // Control state, counters and registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= StIdle;
         trigger_q <= 1'b0;
         cnt_q     <= '0;
         pidx_q    <= '0;
         trig_q    <= '0;
         done_q    <= 1'b0;
         align_q   <= 1'b0;
         perr_q    <= '0;
      end else begin
         state_q   <= state_d;
         trigger_q <= trigger;
         cnt_q     <= cnt_d;
         pidx_q    <= pidx_d;
         trig_q    <= trig_d;
         done_q    <= done_d;
         align_q   <= align_d;
         perr_q    <= perr_d;
      end
   end

   // Run configuration snapshot, taken on the ARMED -> RUN transition
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         en_q     <= '0;
         phase_q  <= '0;
         width_q  <= '0;
         repeat_q <= '0;
         ratio_q  <= '0;
      end else if (latch_cfg) begin
         en_q     <= ch_en;
         phase_q  <= ch_phase;
         width_q  <= ch_width;
         repeat_q <= repeat_count;
         ratio_q  <= bsync_ratio;
      end
   end

   assign trig_out    = trig_q;
   assign busy        = (state_q == StArmed) || (state_q == StRun);
   assign state       = state_q;
   assign done        = done_q;
   assign align_error = align_q;
   assign phase_error = perr_q;

endmodule
